arm_mem_arbiter: RTL and testbench
==================================

// Module: arm_mem_arbiter
// PURPOSE
// - Shares one unified memory port between the CPU instruction-fetch path and data path.
// - Registered request/grant FSM with round-robin fairness under contention.
// - Sits between ARM_SingleCycle_CPU fetch/load-store logic and the single-ported memory model.
// - Per-requester ready pulses double as stall release.
// PARAMETERS
// - BusWidth       32   address/data width
// - TimeoutCycles  255  max ACC cycles before abort; ARB_TIMEOUT_EN only; legal range 1..65535
// PORTS
// - i_CLK      in   1   clock, rising edge
// - i_RESET    in   1   asynchronous reset, active-low
// - i_IF_Req   in   1   fetch request; held until o_IF_Ready
// - i_IF_Addr  in   BW  fetch address
// - o_IF_Ready out  1   one-cycle pulse: o_IF_Instr valid
// - o_IF_Instr out  BW  fetched instruction (registered)
// - i_D_Req    in   1   data request; held until o_D_Ready
// - i_D_Write  in   1   1 = store, 0 = load
// - i_D_Addr   in   BW  data address
// - i_D_WData  in   BW  store data
// - o_D_Ready  out  1   one-cycle pulse: data access complete
// - o_D_RData  out  BW  load data (registered)
// - o_M_Valid  out  1   memory access active
// - o_M_Write  out  1   memory write strobe
// - o_M_Addr   out  BW  memory address
// - o_M_WData  out  BW  memory write data
// - i_M_Ready  in   1   memory completes current access this cycle
// - i_M_RData  in   BW  memory read data, valid with i_M_Ready
// - o_Timeout  out  1   sticky abort flag; tied 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
// - Reset (i_RESET=0, async): state=IDLE; last_grant=DATA; timeout counter=0.
//   All outputs 0, including addr/data buses. Reset mid-access: the access is dropped and no Ready is pulsed.
// - States:
//   - IDLE: o_M_Valid=0, o_M_Write=0; o_M_Addr/o_M_WData hold their last values.
//   - IF_ACC and D_ACC: o_M_Valid=1; o_M_Addr/o_M_WData/o_M_Write are stable for the whole state.
// - IDLE arbitration, at the clock edge:
//   - Eff_req = Req & ~Ready. A requester whose Ready is high this cycle is ignored.
//   - Only one requester has eff_req: grant it.
//   - Both have eff_req: grant the requester opposite to last_grant, then update last_grant.
//   - Grant IF: latch i_IF_Addr, o_M_Write=0, go to IF_ACC.
//   - Grant D: latch i_D_Addr, i_D_WData and i_D_Write, go to D_ACC.
// - In xx_ACC with i_M_Ready=1:
//   - Capture i_M_RData into o_IF_Instr (IF) or o_D_RData (D loads only; unchanged on stores).
//   - Pulse the matching Ready for exactly 1 cycle, then return to IDLE.
// - Latency:
//   - Request high in cycle N (state IDLE) gives o_M_Valid in N+1.
//   - With zero-wait memory, Ready is high in N+2.
//   - Each memory wait cycle adds one cycle.
// - Throughput: one access per 2 cycles. The IDLE cycle carrying Ready can grant the other requester.
// - Requester changing Addr/WData while its access is in flight: no effect, values are latched at grant.
// - i_M_Ready while in IDLE is ignored.
// - The Ready pulses are mutually exclusive: never both high.
// CONFIGURATION
// - ARB_TIMEOUT_EN defined:
//   - A 16-bit counter clears on entry to ACC and increments each ACC cycle without i_M_Ready.
//   - When the counter reaches TimeoutCycles, the access aborts: return to IDLE, pulse the matching Ready.
//   - On abort, the matching data output is forced to 0 and o_Timeout sets (sticky until reset).
//   - i_M_Ready in the same cycle as expiry wins: normal completion, no timeout.
// - ARB_TIMEOUT_EN undefined: no counter; ACC waits indefinitely; o_Timeout is constant 0.
// TESTING
// - Reset while in D_ACC -> next cycle all outputs 0, state IDLE; no o_D_Ready pulse.
// - Single fetch:
//   - Stimulus: IF_Req with addr 0x100, zero-wait memory returning 0xE3A01005.
//   - Response: o_M_Valid in cycle 1 with o_M_Addr=0x100; o_IF_Ready with o_IF_Instr=0xE3A01005 in cycle 2.
// - Store with 3 wait cycles:
//   - Stimulus: D addr 0x20, WData 0x55.
//   - Response: o_M_Write=1 held for 4 cycles, o_D_Ready in cycle 5, o_D_RData unchanged.
// - Contention:
//   - Stimulus: IF and D requests held continuously from reset.
//   - Response: grants IF, D, IF, D..., with o_M_Valid high in cycles 1, 3, 5...
// - Ready masking: a requester keeps Req high during its Ready cycle -> it is not re-granted that cycle.
// - ARB_TIMEOUT_EN, TimeoutCycles=4, i_M_Ready=0:
//   - Response: o_IF_Ready with o_IF_Instr=0 after 4 ACC cycles; o_Timeout=1 until reset.
//   - i_M_Ready high exactly at expiry: normal data returned, o_Timeout stays 0.

Source files
------------

// File: rtl/arm_mem_arbiter_if.sv
// Bus bundle between the arbiter, the fetch/load-store requesters and the single-ported memory.
// The slave modport is the arbiter's view; the master modport is the CPU-plus-memory side.
interface arm_mem_arbiter_if #(
    parameter int BusWidth = 32
);
    logic                i_IF_Req;
    logic [BusWidth-1:0] i_IF_Addr;
    logic                o_IF_Ready;
    logic [BusWidth-1:0] o_IF_Instr;

    logic                i_D_Req;
    logic                i_D_Write;
    logic [BusWidth-1:0] i_D_Addr;
    logic [BusWidth-1:0] i_D_WData;
    logic                o_D_Ready;
    logic [BusWidth-1:0] o_D_RData;

    logic                o_M_Valid;
    logic                o_M_Write;
    logic [BusWidth-1:0] o_M_Addr;
    logic [BusWidth-1:0] o_M_WData;
    logic                i_M_Ready;
    logic [BusWidth-1:0] i_M_RData;

    logic                o_Timeout;

    modport slave (
        input  i_IF_Req, i_IF_Addr,
        output o_IF_Ready, o_IF_Instr,
        input  i_D_Req, i_D_Write, i_D_Addr, i_D_WData,
        output o_D_Ready, o_D_RData,
        output o_M_Valid, o_M_Write, o_M_Addr, o_M_WData,
        input  i_M_Ready, i_M_RData,
        output o_Timeout
    );

    modport master (
        output i_IF_Req, i_IF_Addr,
        input  o_IF_Ready, o_IF_Instr,
        output i_D_Req, i_D_Write, i_D_Addr, i_D_WData,
        input  o_D_Ready, o_D_RData,
        input  o_M_Valid, o_M_Write, o_M_Addr, o_M_WData,
        output i_M_Ready, i_M_RData,
        input  o_Timeout
    );
endinterface

// File: rtl/arm_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Optional access timeout is built when ARB_TIMEOUT_EN is defined (adds TimeoutCycles).
module arm_mem_arbiter #(
    parameter int BusWidth = 32
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TimeoutCycles = 255
`endif
) (
    input  logic             i_CLK,
    input  logic             i_RESET,
    arm_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IF_ACC = 2'd1,
        ST_D_ACC  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_last_d;
    logic                r_m_valid;
    logic                r_m_write;
    logic [BusWidth-1:0] r_m_addr;
    logic [BusWidth-1:0] r_m_wdata;
    logic                r_if_ready;
    logic [BusWidth-1:0] r_if_instr;
    logic                r_d_ready;
    logic [BusWidth-1:0] r_d_rdata;

    state_t              w_state_nxt;
    logic                w_last_d_nxt;
    logic                w_m_valid_nxt;
    logic                w_m_write_nxt;
    logic [BusWidth-1:0] w_m_addr_nxt;
    logic [BusWidth-1:0] w_m_wdata_nxt;
    logic                w_if_ready_nxt;
    logic [BusWidth-1:0] w_if_instr_nxt;
    logic                w_d_ready_nxt;
    logic [BusWidth-1:0] w_d_rdata_nxt;
    logic                w_if_eff;
    logic                w_d_eff;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TimeoutCycles - 1);

    logic [15:0] r_tmo_cnt;
    logic        r_timeout;
    logic [15:0] w_tmo_cnt_nxt;
    logic        w_timeout_nxt;
`endif

    // State register and registered outputs.
    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            r_state    <= ST_IDLE;
            r_last_d   <= 1'b1;
            r_m_valid  <= 1'b0;
            r_m_write  <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_if_ready <= 1'b0;
            r_if_instr <= '0;
            r_d_ready  <= 1'b0;
            r_d_rdata  <= '0;
`ifdef ARB_TIMEOUT_EN
            r_tmo_cnt  <= 16'd0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_last_d   <= w_last_d_nxt;
            r_m_valid  <= w_m_valid_nxt;
            r_m_write  <= w_m_write_nxt;
            r_m_addr   <= w_m_addr_nxt;
            r_m_wdata  <= w_m_wdata_nxt;
            r_if_ready <= w_if_ready_nxt;
            r_if_instr <= w_if_instr_nxt;
            r_d_ready  <= w_d_ready_nxt;
            r_d_rdata  <= w_d_rdata_nxt;
`ifdef ARB_TIMEOUT_EN
            r_tmo_cnt  <= w_tmo_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
`endif
        end
    end

    // Next-state, arbitration and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_last_d_nxt   = r_last_d;
        w_m_valid_nxt  = r_m_valid;
        w_m_write_nxt  = r_m_write;
        w_m_addr_nxt   = r_m_addr;
        w_m_wdata_nxt  = r_m_wdata;
        w_if_ready_nxt = 1'b0;
        w_if_instr_nxt = r_if_instr;
        w_d_ready_nxt  = 1'b0;
        w_d_rdata_nxt  = r_d_rdata;
`ifdef ARB_TIMEOUT_EN
        w_tmo_cnt_nxt  = r_tmo_cnt;
        w_timeout_nxt  = r_timeout;
`endif
        // A requester whose Ready is showing this cycle is still holding its old request.
        w_if_eff = bus.i_IF_Req & ~r_if_ready;
        w_d_eff  = bus.i_D_Req & ~r_d_ready;

        case (r_state)
            ST_IDLE: begin
                w_m_valid_nxt = 1'b0;
                w_m_write_nxt = 1'b0;
                // Round-robin pointer only moves when both sides actually contend.
                if (w_if_eff && (!w_d_eff || r_last_d)) begin
                    w_state_nxt   = ST_IF_ACC;
                    w_m_valid_nxt = 1'b1;
                    w_m_write_nxt = 1'b0;
                    w_m_addr_nxt  = bus.i_IF_Addr;
                    if (w_d_eff) begin
                        w_last_d_nxt = 1'b0;
                    end else begin
                        w_last_d_nxt = r_last_d;
                    end
`ifdef ARB_TIMEOUT_EN
                    w_tmo_cnt_nxt = 16'd0;
`endif
                end else if (w_d_eff) begin
                    w_state_nxt   = ST_D_ACC;
                    w_m_valid_nxt = 1'b1;
                    w_m_write_nxt = bus.i_D_Write;
                    w_m_addr_nxt  = bus.i_D_Addr;
                    w_m_wdata_nxt = bus.i_D_WData;
                    if (w_if_eff) begin
                        w_last_d_nxt = 1'b1;
                    end else begin
                        w_last_d_nxt = r_last_d;
                    end
`ifdef ARB_TIMEOUT_EN
                    w_tmo_cnt_nxt = 16'd0;
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_IF_ACC, ST_D_ACC: begin
                if (bus.i_M_Ready) begin
                    w_state_nxt   = ST_IDLE;
                    w_m_valid_nxt = 1'b0;
                    w_m_write_nxt = 1'b0;
                    if (r_state == ST_IF_ACC) begin
                        w_if_ready_nxt = 1'b1;
                        w_if_instr_nxt = bus.i_M_RData;
                    end else begin
                        w_d_ready_nxt = 1'b1;
                        // Stores leave the last load result visible.
                        if (!r_m_write) begin
                            w_d_rdata_nxt = bus.i_M_RData;
                        end else begin
                            w_d_rdata_nxt = r_d_rdata;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_m_valid_nxt = 1'b0;
                    w_m_write_nxt = 1'b0;
                    w_timeout_nxt = 1'b1;
                    if (r_state == ST_IF_ACC) begin
                        w_if_ready_nxt = 1'b1;
                        w_if_instr_nxt = '0;
                    end else begin
                        w_d_ready_nxt = 1'b1;
                        w_d_rdata_nxt = '0;
                    end
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 16'd1;
                end
`else
                end else begin
                    w_state_nxt = r_state;
                end
`endif
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_m_valid_nxt = 1'b0;
                w_m_write_nxt = 1'b0;
            end
        endcase
    end

    assign bus.o_M_Valid  = r_m_valid;
    assign bus.o_M_Write  = r_m_write;
    assign bus.o_M_Addr   = r_m_addr;
    assign bus.o_M_WData  = r_m_wdata;
    assign bus.o_IF_Ready = r_if_ready;
    assign bus.o_IF_Instr = r_if_instr;
    assign bus.o_D_Ready  = r_d_ready;
    assign bus.o_D_RData  = r_d_rdata;
`ifdef ARB_TIMEOUT_EN
    assign bus.o_Timeout  = r_timeout;
`else
    assign bus.o_Timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_arm_mem_arbiter.sv
// Self-checking bench for arm_mem_arbiter: directed scenarios plus randomized requesters and
// memory, compared cycle by cycle against a transaction-level reference model.
module tb_arm_mem_arbiter;
    localparam int BW = 32;
`ifdef ARB_TIMEOUT_EN
    localparam int TMO = 4;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    arm_mem_arbiter_if #(.BusWidth(BW)) bus ();

    arm_mem_arbiter #(
        .BusWidth(BW)
`ifdef ARB_TIMEOUT_EN
        , .TimeoutCycles(TMO)
`endif
    ) dut (
        .i_CLK  (clk),
        .i_RESET(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: which requester owns the port, how long it has been waiting,
    // and the output values the arbiter must present next cycle.
    bit          m_busy;
    bit          m_own_d;
    bit          m_last_d;
    int          m_acc_cycles;
    logic        e_valid, e_write, e_if_ready, e_d_ready, e_timeout;
    logic [31:0] e_addr, e_wdata, e_if_instr, e_d_rdata;

    // Random memory responder bookkeeping.
    bit mem_active;
    int mem_tgt;
    int mem_cnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check("m_valid",  32'(bus.o_M_Valid),  32'(e_valid));
        check("m_write",  32'(bus.o_M_Write),  32'(e_write));
        check("m_addr",   bus.o_M_Addr,        e_addr);
        check("m_wdata",  bus.o_M_WData,       e_wdata);
        check("if_ready", 32'(bus.o_IF_Ready), 32'(e_if_ready));
        check("if_instr", bus.o_IF_Instr,      e_if_instr);
        check("d_ready",  32'(bus.o_D_Ready),  32'(e_d_ready));
        check("d_rdata",  bus.o_D_RData,       e_d_rdata);
        check("timeout",  32'(bus.o_Timeout),  32'(e_timeout));
        check("ready_excl", 32'(bus.o_IF_Ready & bus.o_D_Ready), 32'd0);
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_own_d = 1'b0; m_last_d = 1'b1; m_acc_cycles = 0;
        e_valid = 1'b0; e_write = 1'b0; e_if_ready = 1'b0; e_d_ready = 1'b0; e_timeout = 1'b0;
        e_addr = 32'd0; e_wdata = 32'd0; e_if_instr = 32'd0; e_d_rdata = 32'd0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit if_eff, d_eff, take_d, nx_if_rdy, nx_d_rdy;
        nx_if_rdy = 1'b0;
        nx_d_rdy  = 1'b0;
        if (!m_busy) begin
            if_eff = bus.i_IF_Req && !e_if_ready;
            d_eff  = bus.i_D_Req && !e_d_ready;
            if (if_eff && d_eff) begin
                take_d   = !m_last_d;
                m_last_d = take_d;
            end else begin
                take_d = d_eff;
            end
            if (if_eff || d_eff) begin
                m_busy = 1'b1; m_own_d = take_d; m_acc_cycles = 0; e_valid = 1'b1;
                if (take_d) begin
                    e_addr = bus.i_D_Addr; e_wdata = bus.i_D_WData; e_write = bus.i_D_Write;
                end else begin
                    e_addr = bus.i_IF_Addr; e_write = 1'b0;
                end
            end else begin
                e_valid = 1'b0; e_write = 1'b0;
            end
        end else begin
            m_acc_cycles++;
            if (bus.i_M_Ready) begin
                if (m_own_d) begin
                    nx_d_rdy = 1'b1;
                    if (!e_write) e_d_rdata = bus.i_M_RData;
                end else begin
                    nx_if_rdy  = 1'b1;
                    e_if_instr = bus.i_M_RData;
                end
                m_busy = 1'b0; e_valid = 1'b0; e_write = 1'b0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (m_acc_cycles == TMO) begin
                if (m_own_d) begin
                    nx_d_rdy = 1'b1; e_d_rdata = 32'd0;
                end else begin
                    nx_if_rdy = 1'b1; e_if_instr = 32'd0;
                end
                e_timeout = 1'b1;
                m_busy = 1'b0; e_valid = 1'b0; e_write = 1'b0;
            end
`endif
        end
        e_if_ready = nx_if_rdy;
        e_d_ready  = nx_d_rdy;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic drive_idle();
        bus.i_IF_Req = 1'b0; bus.i_IF_Addr = 32'd0;
        bus.i_D_Req = 1'b0; bus.i_D_Write = 1'b0; bus.i_D_Addr = 32'd0; bus.i_D_WData = 32'd0;
        bus.i_M_Ready = 1'b0; bus.i_M_RData = 32'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        mem_active = 1'b0;
        #1;
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rnd;
        drive_idle();
        model_reset();
        @(negedge clk);
        do_reset();

        // Single zero-wait fetch, then Ready masking with the request still held.
        bus.i_IF_Req = 1'b1; bus.i_IF_Addr = 32'h0000_0100;
        bus.i_M_Ready = 1'b1; bus.i_M_RData = 32'hE3A0_1005;
        tick();
        check("fetch_valid_c1", 32'(bus.o_M_Valid), 32'd1);
        check("fetch_addr_c1", bus.o_M_Addr, 32'h0000_0100);
        tick();
        check("fetch_ready_c2", 32'(bus.o_IF_Ready), 32'd1);
        check("fetch_instr_c2", bus.o_IF_Instr, 32'hE3A0_1005);
        tick();
        check("mask_no_regrant", 32'(bus.o_M_Valid), 32'd0);
        bus.i_IF_Req = 1'b0; bus.i_M_Ready = 1'b0;
        tick();

        // Load, then a store with three wait states that must not disturb o_D_RData.
        bus.i_D_Req = 1'b1; bus.i_D_Write = 1'b0; bus.i_D_Addr = 32'h30;
        bus.i_M_Ready = 1'b1; bus.i_M_RData = 32'hCAFE_F00D;
        tick();
        tick();
        check("load_rdata", bus.o_D_RData, 32'hCAFE_F00D);
        bus.i_D_Req = 1'b0; bus.i_M_Ready = 1'b0;
        tick();
        bus.i_D_Req = 1'b1; bus.i_D_Write = 1'b1; bus.i_D_Addr = 32'h20; bus.i_D_WData = 32'h55;
        bus.i_M_RData = 32'h0000_0BAD;
        tick();
        for (int k = 1; k <= 4; k++) begin
            check("store_write_hold", 32'(bus.o_M_Write), 32'd1);
            check("store_addr_hold", bus.o_M_Addr, 32'h20);
            check("store_wdata_hold", bus.o_M_WData, 32'h55);
            bus.i_D_Addr  = 32'h999;
            bus.i_D_WData = $urandom;
            bus.i_M_Ready = (k == 4);
            tick();
        end
        check("store_ready_c5", 32'(bus.o_D_Ready), 32'd1);
        check("store_rdata_kept", bus.o_D_RData, 32'hCAFE_F00D);
        bus.i_D_Req = 1'b0; bus.i_M_Ready = 1'b0;
        tick();

        // Contention from reset: IF, D, IF, ... with o_M_Valid in odd cycles.
        do_reset();
        bus.i_IF_Req = 1'b1; bus.i_IF_Addr = 32'h1000;
        bus.i_D_Req = 1'b1; bus.i_D_Addr = 32'h2000; bus.i_D_Write = 1'b0;
        bus.i_M_Ready = 1'b1; bus.i_M_RData = 32'h7777_0000;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check("cont_valid", 32'(bus.o_M_Valid), 32'(c % 2));
            if (c % 4 == 1) check("cont_if_addr", bus.o_M_Addr, 32'h1000);
            if (c % 4 == 3) check("cont_d_addr", bus.o_M_Addr, 32'h2000);
            if (c % 4 == 2) check("cont_if_ready", 32'(bus.o_IF_Ready), 32'd1);
            if (c % 4 == 0) check("cont_d_ready", 32'(bus.o_D_Ready), 32'd1);
        end

        // Reset while a load is waiting in D_ACC.
        do_reset();
        bus.i_D_Req = 1'b1; bus.i_D_Write = 1'b0; bus.i_D_Addr = 32'h44;
        tick();
        check("rst_mid_busy", 32'(bus.o_M_Valid), 32'd1);
        do_reset();
        check("rst_mid_valid", 32'(bus.o_M_Valid), 32'd0);
        check("rst_mid_addr", bus.o_M_Addr, 32'd0);
        tick();
        check("rst_mid_no_ready", 32'(bus.o_D_Ready), 32'd0);

`ifdef ARB_TIMEOUT_EN
        // Fetch that never completes: aborts after TMO ACC cycles with zeroed data.
        do_reset();
        bus.i_IF_Req = 1'b1; bus.i_IF_Addr = 32'h40;
        bus.i_M_Ready = 1'b1; bus.i_M_RData = 32'hAAAA_5555;
        tick();
        tick();
        check("tmo_pre_instr", bus.o_IF_Instr, 32'hAAAA_5555);
        bus.i_IF_Req = 1'b0; bus.i_M_Ready = 1'b0;
        tick();
        bus.i_IF_Req = 1'b1;
        tick();
        repeat (4) tick();
        check("tmo_ready", 32'(bus.o_IF_Ready), 32'd1);
        check("tmo_instr_zero", bus.o_IF_Instr, 32'd0);
        check("tmo_flag", 32'(bus.o_Timeout), 32'd1);
        bus.i_IF_Req = 1'b0;
        repeat (3) tick();
        check("tmo_sticky", 32'(bus.o_Timeout), 32'd1);
        do_reset();
        check("tmo_cleared", 32'(bus.o_Timeout), 32'd0);

        // Memory ready exactly on the expiry cycle completes normally.
        bus.i_IF_Req = 1'b1; bus.i_IF_Addr = 32'h44;
        repeat (4) tick();
        bus.i_M_Ready = 1'b1; bus.i_M_RData = 32'h1234_5678;
        tick();
        check("tmo_edge_ready", 32'(bus.o_IF_Ready), 32'd1);
        check("tmo_edge_instr", bus.o_IF_Instr, 32'h1234_5678);
        check("tmo_edge_flag", 32'(bus.o_Timeout), 32'd0);
        bus.i_IF_Req = 1'b0; bus.i_M_Ready = 1'b0;
        tick();
`endif

        // Randomized requesters and memory with random wait states.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if (!bus.i_IF_Req) bus.i_IF_Req = ($urandom_range(0, 1) == 0);
            else if (bus.o_IF_Ready && $urandom_range(0, 1) == 0) bus.i_IF_Req = 1'b0;
            if ($urandom_range(0, 3) == 0) bus.i_IF_Addr = $urandom;
            if (!bus.i_D_Req) begin
                bus.i_D_Req = ($urandom_range(0, 2) == 0);
                bus.i_D_Write = $urandom_range(0, 1);
            end else if (bus.o_D_Ready && $urandom_range(0, 1) == 0) begin
                bus.i_D_Req = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) bus.i_D_Addr = $urandom;
            if ($urandom_range(0, 3) == 0) bus.i_D_WData = $urandom;
            if (bus.o_M_Valid) begin
                if (!mem_active) begin
                    mem_active = 1'b1; mem_tgt = $urandom_range(0, 5); mem_cnt = 0;
                end
                bus.i_M_Ready = (mem_cnt == mem_tgt);
                mem_cnt++;
                if (bus.i_M_Ready) mem_active = 1'b0;
            end else begin
                mem_active = 1'b0;
                bus.i_M_Ready = $urandom_range(0, 1);
            end
            rnd = $urandom;
            bus.i_M_RData = rnd;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
